// File: rtl/tracking_pkg.sv
// Shared types and helpers for the multi-channel presence filter.
package tracking_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } track_state_t;

  // Hold time in clk cycles: MHz * 1000 cycles per millisecond.
  function automatic int unsigned hold_cycles(input int unsigned mhz, input int unsigned ms);
    return mhz * 32'd1000 * ms;
  endfunction

endpackage

// File: rtl/tracking_channel.sv
// Single-channel presence filter: acquisition debounce, hold-after-loss timer,
// and one-cycle acquired/lost event pulses.
module tracking_channel
  import tracking_pkg::*;
#(
  parameter int unsigned ACQ_CYCLES  = 1,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic detect,
  output logic on_screen,
  output logic acquired,
  output logic lost,
  output logic on_screen_nxt_c
);

  localparam int unsigned ACQ_W  = $clog2(ACQ_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  track_state_t      state, state_nxt;
  logic [ACQ_W-1:0]  acq_cnt, acq_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              acquired_nxt, lost_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acq_cnt   <= '0;
      hold_cnt  <= '0;
      on_screen <= 1'b0;
      acquired  <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acq_cnt   <= acq_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      on_screen <= on_screen_nxt_c;
      acquired  <= acquired_nxt;
      lost      <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acq_cnt_nxt  = acq_cnt;
    hold_cnt_nxt = hold_cnt;
    acquired_nxt = 1'b0;
    lost_nxt     = 1'b0;

    // Clear/disable overrides detection; a visible object reports loss.
    if (clear || !enable) begin
      state_nxt    = IDLE;
      acq_cnt_nxt  = '0;
      hold_cnt_nxt = '0;
      lost_nxt     = (state == TRACK) || (state == HOLD);
    end else begin
      case (state)
        IDLE: begin
          if (detect) begin
            if (ACQ_CYCLES == 1) begin
              state_nxt    = TRACK;
              acquired_nxt = 1'b1;
            end else begin
              state_nxt   = ACQUIRE;
              acq_cnt_nxt = ACQ_W'(1);
            end
          end
        end
        ACQUIRE: begin
          if (!detect) begin
            state_nxt   = IDLE;
            acq_cnt_nxt = '0;
          end else if ((acq_cnt + ACQ_W'(1)) == ACQ_W'(ACQ_CYCLES)) begin
            state_nxt    = TRACK;
            acq_cnt_nxt  = '0;
            acquired_nxt = 1'b1;
          end else begin
            acq_cnt_nxt = acq_cnt + ACQ_W'(1);
          end
        end
        TRACK: begin
          if (!detect) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_W'(1);
          end
        end
        HOLD: begin
          // Detection rearms the timer; expiry needs HOLD_CYCLES+1 lows in a row.
          if (detect) begin
            state_nxt    = TRACK;
            hold_cnt_nxt = '0;
          end else if (hold_cnt == HOLD_W'(HOLD_CYCLES)) begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
            lost_nxt     = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_nxt    = IDLE;
          acq_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
        end
      endcase
    end

    on_screen_nxt_c = (state_nxt == TRACK) || (state_nxt == HOLD);
  end

endmodule

// File: rtl/multi_tracking_buffer.sv
// NUM_CH independent presence filters with registered OR/popcount aggregates
// aligned to on_screen.
module multi_tracking_buffer
  import tracking_pkg::*;
#(
  parameter int unsigned NUM_CH                   = 4,
  parameter int unsigned CLOCK_FREQUENCY_MHZ      = 25,
  parameter int unsigned BUFFER_TIME_MILLISECONDS = 100,
  parameter int unsigned ACQ_CYCLES               = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           enable,
  input  logic [NUM_CH-1:0]           clear,
  input  logic [NUM_CH-1:0]           oObjectDetected,
  output logic [NUM_CH-1:0]           on_screen,
  output logic [NUM_CH-1:0]           acquired,
  output logic [NUM_CH-1:0]           lost,
  output logic                        any_on_screen,
  output logic [$clog2(NUM_CH+1)-1:0] num_on_screen
);

  localparam int unsigned CNT_W       = $clog2(NUM_CH + 1);
  localparam int unsigned HOLD_CYCLES = hold_cycles(CLOCK_FREQUENCY_MHZ, BUFFER_TIME_MILLISECONDS);

  logic [NUM_CH-1:0] on_screen_nxt;
  logic [CNT_W-1:0]  num_nxt;
  logic              any_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tracking_channel #(
      .ACQ_CYCLES  (ACQ_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable[i]),
      .clear           (clear[i]),
      .detect          (oObjectDetected[i]),
      .on_screen       (on_screen[i]),
      .acquired        (acquired[i]),
      .lost            (lost[i]),
      .on_screen_nxt_c (on_screen_nxt[i])
    );
  end

  // Aggregates built from next-state values so they land with on_screen.
  always_comb begin
    num_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      num_nxt = num_nxt + CNT_W'(on_screen_nxt[i]);
    end
    any_nxt = |on_screen_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_on_screen <= 1'b0;
      num_on_screen <= '0;
    end else begin
      any_on_screen <= any_nxt;
      num_on_screen <= num_nxt;
    end
  end

endmodule

// File: tb/tb_multi_tracking_buffer.sv
// Directed bench for multi_tracking_buffer: NUM_CH=4, HOLD_CYCLES=1000, ACQ_CYCLES=3.
module tb_multi_tracking_buffer;

  logic       clk;
  logic       rst_n;
  logic [3:0] enable;
  logic [3:0] clear;
  logic [3:0] det;
  logic [3:0] on_screen;
  logic [3:0] acquired;
  logic [3:0] lost;
  logic       any_on_screen;
  logic [2:0] num_on_screen;

  int n_checks;
  int n_fail;

  multi_tracking_buffer #(
    .NUM_CH                   (4),
    .CLOCK_FREQUENCY_MHZ      (1),
    .BUFFER_TIME_MILLISECONDS (1),
    .ACQ_CYCLES               (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .clear           (clear),
    .oObjectDetected (det),
    .on_screen       (on_screen),
    .acquired        (acquired),
    .lost            (lost),
    .any_on_screen   (any_on_screen),
    .num_on_screen   (num_on_screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acq_pulses;
    int lost_pulses;
    int drops;
    int fall_k;
    int lost_k;
    int any_out;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    enable   = 4'hF;
    clear    = 4'h0;
    det      = 4'h0;
    tick();
    tick();
    check("reset_on_screen", 32'(on_screen), 32'h0);
    check("reset_acquired", 32'(acquired), 32'h0);
    check("reset_lost", 32'(lost), 32'h0);
    check("reset_any", 32'(any_on_screen), 32'h0);
    check("reset_num", 32'(num_on_screen), 32'h0);
    rst_n = 1'b1;

    // 1: acquisition after the third consecutive high sample
    det = 4'b0001;
    tick();
    check("t1_s1_on", 32'(on_screen), 32'h0);
    tick();
    check("t1_s2_on", 32'(on_screen), 32'h0);
    check("t1_s2_acq", 32'(acquired), 32'h0);
    tick();
    check("t1_s3_on", 32'(on_screen), 32'h1);
    check("t1_s3_acq", 32'(acquired), 32'h1);
    check("t1_s3_num", 32'(num_on_screen), 32'h1);
    check("t1_s3_any", 32'(any_on_screen), 32'h1);
    acq_pulses = 0;
    drops = 0;
    for (int k = 0; k < 97; k++) begin
      tick();
      if (acquired[0]) acq_pulses++;
      if (!on_screen[0]) drops++;
    end
    check("t1_extra_acq", 32'(acq_pulses), 32'h0);
    check("t1_drops", 32'(drops), 32'h0);

    // 3: gaps shorter than the hold time never drop presence
    acq_pulses = 0;
    lost_pulses = 0;
    drops = 0;
    det = 4'b0000;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (acquired[0]) acq_pulses++;
      if (lost[0]) lost_pulses++;
      if (!on_screen[0]) drops++;
    end
    det = 4'b0001;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (acquired[0]) acq_pulses++;
      if (lost[0]) lost_pulses++;
      if (!on_screen[0]) drops++;
    end
    det = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (acquired[0]) acq_pulses++;
      if (lost[0]) lost_pulses++;
      if (!on_screen[0]) drops++;
    end
    check("t3_hold_acq", 32'(acq_pulses), 32'h0);
    check("t3_hold_lost", 32'(lost_pulses), 32'h0);
    check("t3_hold_drops", 32'(drops), 32'h0);
    // 1001st consecutive low falls at step 401 of the next 1000
    lost_pulses = 0;
    fall_k = 0;
    lost_k = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (lost[0]) begin
        lost_pulses++;
        lost_k = k;
      end
      if (!on_screen[0] && fall_k == 0) fall_k = k;
    end
    check("t3_lost_count", 32'(lost_pulses), 32'h1);
    check("t3_lost_step", 32'(lost_k), 32'd401);
    check("t3_fall_step", 32'(fall_k), 32'd401);
    check("t3_end_on", 32'(on_screen), 32'h0);
    check("t3_end_num", 32'(num_on_screen), 32'h0);

    // 2: two highs are not enough
    any_out = 0;
    det = 4'b0001;
    tick();
    if (on_screen[0] || acquired[0] || lost[0]) any_out++;
    tick();
    if (on_screen[0] || acquired[0] || lost[0]) any_out++;
    det = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (on_screen[0] || acquired[0] || lost[0]) any_out++;
    end
    check("t2_no_activity", 32'(any_out), 32'h0);

    // 4: clear while tracking, then full re-acquisition
    det = 4'b0010;
    tick();
    tick();
    tick();
    check("t4_track_on", 32'(on_screen), 32'h2);
    clear = 4'b0010;
    tick();
    clear = 4'b0000;
    check("t4_clear_on", 32'(on_screen), 32'h0);
    check("t4_clear_lost", 32'(lost), 32'h2);
    check("t4_clear_acq", 32'(acquired), 32'h0);
    tick();
    check("t4_re1_on", 32'(on_screen), 32'h0);
    check("t4_re1_lost", 32'(lost), 32'h0);
    tick();
    check("t4_re2_on", 32'(on_screen), 32'h0);
    tick();
    check("t4_re3_on", 32'(on_screen), 32'h2);
    check("t4_re3_acq", 32'(acquired), 32'h2);

    // disable everything: only ch1 was visible
    enable = 4'h0;
    tick();
    check("dis_lost", 32'(lost), 32'h2);
    check("dis_on", 32'(on_screen), 32'h0);
    check("dis_num", 32'(num_on_screen), 32'h0);
    enable = 4'hF;

    // 5: simultaneous acquisition on all channels
    det = 4'hF;
    tick();
    tick();
    check("t5_s2_acq", 32'(acquired), 32'h0);
    check("t5_s2_num", 32'(num_on_screen), 32'h0);
    tick();
    check("t5_acq", 32'(acquired), 32'hF);
    check("t5_on", 32'(on_screen), 32'hF);
    check("t5_num", 32'(num_on_screen), 32'h4);
    check("t5_any", 32'(any_on_screen), 32'h1);
    tick();
    check("t5_acq_once", 32'(acquired), 32'h0);

    // 6: reset in the middle of HOLD
    det = 4'h0;
    for (int k = 0; k < 10; k++) tick();
    check("t6_hold_on", 32'(on_screen), 32'hF);
    rst_n = 1'b0;
    tick();
    check("t6_rst_on", 32'(on_screen), 32'h0);
    check("t6_rst_lost", 32'(lost), 32'h0);
    check("t6_rst_num", 32'(num_on_screen), 32'h0);
    check("t6_rst_any", 32'(any_on_screen), 32'h0);
    rst_n = 1'b1;
    det = 4'hF;
    tick();
    tick();
    check("t6_re2_on", 32'(on_screen), 32'h0);
    tick();
    check("t6_re3_on", 32'(on_screen), 32'hF);
    check("t6_re3_acq", 32'(acquired), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
